// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequences PC+4 fetch requests over valid/ready, applies ID/EX
// redirects with a one-cycle bubble, flush pulses, misalignment fault and redirect counting.
module pc_redirect_ctrl #(
    parameter int unsigned         PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
    parameter int unsigned         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [PC_WIDTH-1:0]  fetch_pc,
    input  logic                 id_redirect_valid,
    input  logic [PC_WIDTH-1:0]  id_redirect_target,
    input  logic                 ex_redirect_valid,
    input  logic [PC_WIDTH-1:0]  ex_redirect_target,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic                  fetch_valid_r, fetch_valid_s;
    logic [PC_WIDTH-1:0]   fetch_pc_r, fetch_pc_s;
    logic                  flush_if_id_r, flush_if_id_s;
    logic                  flush_id_ex_r, flush_id_ex_s;
    logic                  misalign_r, misalign_s;
    logic [CNT_WIDTH-1:0]  count_r, count_s;
    logic                  redirect_s;
    logic [PC_WIDTH-1:0]   target_s;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == {CNT_WIDTH{1'b1}}) begin
            return value;
        end else begin
            return value + CNT_WIDTH'(1'b1);
        end
    endfunction

    // Next-state and next-output selection; EX wins over ID because it is the older instruction.
    always_comb begin
        state_s       = state_r;
        fetch_valid_s = fetch_valid_r;
        fetch_pc_s    = fetch_pc_r;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        misalign_s    = misalign_r;
        count_s       = count_r;
        redirect_s    = ex_redirect_valid | id_redirect_valid;
        target_s      = ex_redirect_valid ? ex_redirect_target : id_redirect_target;
        case (state_r)
            ST_BOOT: begin
                state_s       = ST_RUN;
                fetch_valid_s = 1'b1;
            end
            ST_RUN: begin
                if (redirect_s) begin
                    // Any accept in this cycle belongs to the wrong path and is dropped.
                    fetch_valid_s = 1'b0;
                    flush_if_id_s = 1'b1;
                    flush_id_ex_s = ex_redirect_valid;
                    if (is_aligned(target_s[1:0])) begin
                        state_s    = ST_BUBBLE;
                        fetch_pc_s = target_s;
                        count_s    = sat_inc(count_r);
                    end else begin
                        state_s    = ST_FAULT;
                        misalign_s = 1'b1;
                    end
                end else begin
                    fetch_valid_s = ~stall;
                    if (fetch_valid_r & fetch_ready) begin
                        fetch_pc_s = fetch_pc_r + PC_WIDTH'(3'd4);
                    end else begin
                        fetch_pc_s = fetch_pc_r;
                    end
                end
            end
            ST_BUBBLE: begin
                state_s       = ST_RUN;
                fetch_valid_s = ~stall;
            end
            ST_FAULT: begin
                fetch_valid_s = 1'b0;
                misalign_s    = 1'b1;
            end
            default: begin
                state_s       = ST_BOOT;
                fetch_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_BOOT;
            fetch_valid_r <= 1'b0;
            fetch_pc_r    <= RESET_PC;
            flush_if_id_r <= 1'b0;
            flush_id_ex_r <= 1'b0;
            misalign_r    <= 1'b0;
            count_r       <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r       <= state_s;
            fetch_valid_r <= fetch_valid_s;
            fetch_pc_r    <= fetch_pc_s;
            flush_if_id_r <= flush_if_id_s;
            flush_id_ex_r <= flush_id_ex_s;
            misalign_r    <= misalign_s;
            count_r       <= count_s;
        end
    end

    assign fetch_valid    = fetch_valid_r;
    assign fetch_pc       = fetch_pc_r;
    assign flush_if_id    = flush_if_id_r;
    assign flush_id_ex    = flush_id_ex_r;
    assign misalign_err   = misalign_r;
    assign redirect_count = count_r;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic,
// expectations from a transaction-level reference model.
module tb_pc_redirect_ctrl;

    localparam int          CW     = 2;
    localparam logic [63:0] RST_PC = 64'h1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          fetch_ready = 1'b0;
    logic          fetch_valid;
    logic [63:0]   fetch_pc;
    logic          id_redirect_valid = 1'b0;
    logic [63:0]   id_redirect_target = 64'h0;
    logic          ex_redirect_valid = 1'b0;
    logic [63:0]   ex_redirect_target = 64'h0;
    logic          flush_if_id;
    logic          flush_id_ex;
    logic          misalign_err;
    logic [CW-1:0] redirect_count;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .PC_WIDTH(64),
        .RESET_PC(RST_PC),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc),
        .id_redirect_valid(id_redirect_valid),
        .id_redirect_target(id_redirect_target),
        .ex_redirect_valid(ex_redirect_valid),
        .ex_redirect_target(ex_redirect_target),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .misalign_err(misalign_err),
        .redirect_count(redirect_count)
    );

    typedef struct packed {
        logic          valid;
        logic [63:0]   pc;
        logic          fl_ifid;
        logic          fl_idex;
        logic          mis;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: what the fetch unit has promised after each clock edge.
    bit          m_booting, m_in_bubble, m_faulted, m_valid, m_fl_ifid, m_fl_idex, m_mis;
    logic [63:0] m_pc;
    int          m_cnt;

    task automatic model_step();
        logic [63:0] tgt;
        m_fl_ifid = 1'b0;
        m_fl_idex = 1'b0;
        if (!rst_n) begin
            m_booting = 1'b1; m_in_bubble = 1'b0; m_faulted = 1'b0;
            m_valid = 1'b0; m_mis = 1'b0; m_pc = RST_PC; m_cnt = 0;
        end else if (m_faulted) begin
            m_valid = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_valid = 1'b1;
        end else if (m_in_bubble) begin
            m_in_bubble = 1'b0;
            m_valid = !stall;
        end else if (ex_redirect_valid || id_redirect_valid) begin
            tgt = ex_redirect_valid ? ex_redirect_target : id_redirect_target;
            m_fl_ifid = 1'b1;
            m_fl_idex = ex_redirect_valid;
            m_valid = 1'b0;
            if ((tgt % 64'd4) != 64'd0) begin
                m_faulted = 1'b1;
                m_mis = 1'b1;
            end else begin
                m_pc = tgt;
                m_in_bubble = 1'b1;
                if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            end
        end else begin
            if (m_valid && fetch_ready) m_pc = m_pc + 64'd4;
            m_valid = !stall;
        end
        exp_q.push_back('{valid: m_valid, pc: m_pc, fl_ifid: m_fl_ifid, fl_idex: m_fl_idex,
                          mis: m_mis, cnt: CW'(m_cnt)});
    endtask

    task automatic drive(input logic rn, input logic st, input logic rdy,
                         input logic idv, input logic [63:0] idt,
                         input logic exv, input logic [63:0] ext);
        @(negedge clk);
        rst_n = rn;
        stall = st;
        fetch_ready = rdy;
        id_redirect_valid = idv;
        id_redirect_target = idt;
        ex_redirect_valid = exv;
        ex_redirect_target = ext;
        model_step();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares each post-edge DUT output against the oldest promise.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("fetch_valid", {63'd0, fetch_valid}, {63'd0, mon_e.valid});
            check("fetch_pc", fetch_pc, mon_e.pc);
            check("flush_if_id", {63'd0, flush_if_id}, {63'd0, mon_e.fl_ifid});
            check("flush_id_ex", {63'd0, flush_id_ex}, {63'd0, mon_e.fl_idex});
            check("misalign_err", {63'd0, misalign_err}, {63'd0, mon_e.mis});
            check("redirect_count", {62'd0, redirect_count}, {62'd0, mon_e.cnt});
        end
    end

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        if ($urandom_range(0, 2) == 0) t = {48'hFFFF_FFFF_FFFF, t[15:0]};
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        int fault_cycles;
        logic rn;
        // Reset and boot, then sequential fetch.
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        // Backpressure, then stall, then reissue.
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        // EX redirect overriding a simultaneous accept.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h2000);
        repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        // ID and EX together under stall; ID redirect during the bubble.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h3000, 1'b1, 64'h4000);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h5000, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        // Counter saturation.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h6000, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h7000);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h8000, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        // PC wrap past the top of the address space.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (4) drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        // Misaligned target: sticky fault until reset.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h2002);
        repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h9000, 1'b1, 64'hA000);
        repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        // Random traffic; a lingering fault is cleared by reset.
        fault_cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            fault_cycles = m_faulted ? fault_cycles + 1 : 0;
            rn = !((fault_cycles > 4) || ($urandom_range(0, 149) == 0));
            drive(rn, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0), rand_target(),
                  ($urandom_range(0, 9) == 0), rand_target());
        end
        repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        @(posedge clk);
        #3;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Owns the architectural fetch PC and sequences it into instruction fetch over a valid/ready handshake. Selects each next PC from three sources: sequential PC+4, an ID-stage redirect (JAL) and an EX-stage redirect (taken branch/JALR); targets come from the jump-target adder. Issues registered pipeline flush pulses and enforces a one-cycle fetch bubble on every redirect. Also detects misaligned targets and counts redirects.

Parameters:
PC_WIDTH, 64, width of PC and target buses
RESET_PC, 0, PC presented after reset (PC_WIDTH bits)
CNT_WIDTH, 16, width of saturating redirect counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  hazard unit: decode cannot accept; freeze fetch
fetch_ready  input  1  instruction memory accepts request
fetch_valid  output  1  request valid
fetch_pc  output  PC_WIDTH  request address
id_redirect_valid  input  1  JAL resolved in ID
id_redirect_target  input  PC_WIDTH  JAL target
ex_redirect_valid  input  1  taken branch / JALR resolved in EX
ex_redirect_target  input  PC_WIDTH  EX target
flush_if_id  output  1  clear IF/ID register (1-cycle pulse)
flush_id_ex  output  1  clear ID/EX register (1-cycle pulse)
misalign_err  output  1  sticky: redirect target not 4-byte aligned
redirect_count  output  CNT_WIDTH  accepted redirects, saturating

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-low (rst_n).
- Reset (rst_n=0 at edge): state=BOOT, fetch_pc=RESET_PC, fetch_valid=0, flush_if_id=0, flush_id_ex=0, misalign_err=0, redirect_count=0. Reset mid-redirect or in FAULT discards everything.
- States: BOOT, RUN, BUBBLE, FAULT. All outputs registered.
- BOOT: one cycle, then RUN with fetch_valid=1, fetch_pc=RESET_PC.
- RUN, no redirect:
  - fetch_valid = !stall (registered from the cycle-before stall; a stall at cycle N gives fetch_valid=0 at N+1).
  - Handshake: fetch_pc must stay stable while fetch_valid=1 and fetch_ready=0.
  - On accept (fetch_valid & fetch_ready at edge): fetch_pc <= fetch_pc+4, mod 2^PC_WIDTH (wraps, no error).
  - Stall freezes fetch_pc.
- RUN, redirect at cycle N:
  - EX has priority over ID when both are valid (older instruction). ID is ignored that cycle; no flush_id_ex from it.
  - Redirect beats stall and beats any pending or simultaneous fetch accept (that accept is discarded by the flush).
  - Target aligned (target[1:0]==0):
    - Cycle N+1: state=BUBBLE, fetch_pc=target, fetch_valid=0.
    - Cycle N+1: flush_if_id=1. flush_id_ex=1 only for an EX redirect.
    - redirect_count += 1, saturating at all-ones.
  - Target misaligned: state=FAULT, misalign_err=1, fetch_valid=0, flushes as for an aligned redirect, counter unchanged.
- BUBBLE: one cycle.
  - Flush pulses drop back to 0.
  - Redirect inputs ignored (they come from wrong-path instructions being flushed).
  - Next state RUN: fetch_valid = !stall, fetch_pc = target. First request at N+2 at the earliest.
- FAULT: fetch_valid=0, PC frozen, all inputs ignored until reset; misalign_err held at 1.
- Redirect-to-new-fetch latency: 2 cycles. Sequential fetch: 1 request per cycle while fetch_ready=1 and stall=0.
- Flush outputs are never high for more than one consecutive cycle.

Test Plan:
- Reset/boot: RESET_PC=0x1000, hold rst_n=0 for 3 cycles, then release -> fetch_valid=0 for 1 cycle, then fetch_pc=0x1000 with valid; with fetch_ready=1, PCs 0x1000, 0x1004, 0x1008 are issued on consecutive cycles.
- Backpressure/stall: fetch_ready=0 for 3 cycles at PC 0x1008 -> fetch_pc stays 0x1008 with valid held. Then assert stall for 2 cycles -> fetch_valid=0 and PC frozen; after stall drops, 0x1008 is reissued.
- EX redirect: ex_redirect_valid with target 0x2000 -> next cycle flush_if_id=1, flush_id_ex=1, fetch_valid=0; the cycle after, fetch_pc=0x2000 with valid; redirect_count=1.
- Simultaneous: ID target 0x3000 and EX target 0x4000 in the same cycle, plus stall=1 -> EX wins, flush_id_ex=1, next fetch is 0x4000. An ID redirect asserted during BUBBLE is ignored and redirect_count is unchanged.
- Misaligned target: EX target 0x2002 -> misalign_err=1 and fetch_valid=0 permanently; later redirects ignored; rst_n=0 clears the error.
- Wrap/saturation: fetch_pc=0xFFFF_FFFF_FFFF_FFFC, accepted -> next fetch_pc=0x0. With CNT_WIDTH=2, 5 redirects -> redirect_count=3.
